// File: rtl/snake_game_ctrl.sv
// Game-flow controller: IDLE/PLAY/RESPAWN/GAME_OVER with lives, score, level and move tick.
// Optional HIGH_SCORE_EN builds a high-score register latched on entry to GAME_OVER.
module snake_game_ctrl #(
  parameter int SCORE_W          = 8,
  parameter int LIVES            = 3,
  parameter int LIVES_W          = 2,
  parameter int LVL_W            = 3,
  parameter int LEVEL_STEP       = 8,
  parameter int BASE_PERIOD      = 12,
  parameter int RESPAWN_FRAMES   = 60,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               down,
  input  logic               left,
  input  logic               right,
  input  logic               frame_tick,
  input  logic [1:0]         collision_state,
  output logic [1:0]         state,
  output logic               apple_trigger,
  output logic               move_tick,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [LVL_W-1:0]   level,
  output logic [SCORE_W-1:0] high_score
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAY      = 2'b01,
    RESPAWN   = 2'b10,
    GAME_OVER = 2'b11
  } state_t;

  localparam int CW   = $clog2(BASE_PERIOD + 1);
  localparam int PW   = ((LVL_W > CW) ? LVL_W : CW) + 1;
  localparam int FMAX = (RESPAWN_FRAMES > OVER_HOLD_FRAMES) ?
                        RESPAWN_FRAMES : OVER_HOLD_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int AW   = $clog2(LEVEL_STEP + 1);

  state_t          st;
  logic            hit_seen;
  logic            apple_seen;
  logic [CW-1:0]   move_cnt;
  logic [FW-1:0]   fcnt;
  logic [AW-1:0]   apple_cnt;

  logic            btn;
  logic            hit_acc;
  logic            apple_acc;
  logic            last_life;
  logic [PW-1:0]   base_w;
  logic [PW-1:0]   lvl_w;
  logic [PW-1:0]   period_w;
  logic [CW-1:0]   period;

  assign state     = st;
  assign btn       = up | down | left | right;
  assign hit_acc   = (st == PLAY) && (collision_state == 2'b01) && !hit_seen;
  assign apple_acc = (st == PLAY) && (collision_state == 2'b10) && !apple_seen;
  assign last_life = (lives == LIVES_W'(1));

  // Move period shrinks with level but never drops below one frame.
  assign base_w   = PW'(BASE_PERIOD);
  assign lvl_w    = PW'(level);
  assign period_w = (base_w > lvl_w) ? (base_w - lvl_w) : PW'(1);
  assign period   = CW'(period_w);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= IDLE;
      apple_trigger <= 1'b0;
      move_tick     <= 1'b0;
      score         <= '0;
      lives         <= LIVES_W'(LIVES);
      level         <= '0;
      hit_seen      <= 1'b0;
      apple_seen    <= 1'b0;
      move_cnt      <= '0;
      fcnt          <= '0;
      apple_cnt     <= '0;
    end else begin
      apple_trigger <= 1'b0;
      move_tick     <= 1'b0;
      // An event coinciding with frame_tick wins and keeps its flag set.
      if (frame_tick) begin
        hit_seen   <= 1'b0;
        apple_seen <= 1'b0;
      end
      if (hit_acc)   hit_seen   <= 1'b1;
      if (apple_acc) apple_seen <= 1'b1;

      unique case (st)
        IDLE: begin
          if (btn) begin
            st        <= PLAY;
            score     <= '0;
            level     <= '0;
            lives     <= LIVES_W'(LIVES);
            apple_cnt <= '0;
            move_cnt  <= CW'(BASE_PERIOD);
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (move_cnt == CW'(1)) begin
              move_tick <= 1'b1;
              move_cnt  <= period;
            end else begin
              move_cnt <= move_cnt - CW'(1);
            end
          end
          if (hit_acc) begin
            fcnt <= '0;
            if (last_life) begin
              lives <= '0;
              st    <= GAME_OVER;
            end else begin
              lives <= lives - LIVES_W'(1);
              st    <= RESPAWN;
            end
          end else if (apple_acc) begin
            apple_trigger <= 1'b1;
            if (!(&score)) score <= score + SCORE_W'(1);
            if (apple_cnt == AW'(LEVEL_STEP - 1)) begin
              apple_cnt <= '0;
              if (!(&level)) level <= level + LVL_W'(1);
            end else begin
              apple_cnt <= apple_cnt + AW'(1);
            end
          end
        end
        RESPAWN: begin
          if (frame_tick) begin
            if (fcnt == FW'(RESPAWN_FRAMES - 1)) begin
              st       <= PLAY;
              fcnt     <= '0;
              move_cnt <= period;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
        end
        GAME_OVER: begin
          if (frame_tick) begin
            if (fcnt == FW'(OVER_HOLD_FRAMES - 1)) begin
              st   <= IDLE;
              fcnt <= '0;
            end else begin
              fcnt <= fcnt + FW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_score <= '0;
    end else if (hit_acc && last_life && (score > high_score)) begin
      high_score <= score;
    end
  end
`else
  assign high_score = '0;
`endif

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl (default parameters).
// Expected high_score depends on HIGH_SCORE_EN.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] collision_state = 2'b00;
  logic [1:0] state;
  logic       apple_trigger;
  logic       move_tick;
  logic [7:0] score;
  logic [1:0] lives;
  logic [2:0] level;
  logic [7:0] high_score;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  int n = 0;
  logic mv;

`ifdef HIGH_SCORE_EN
  localparam logic [7:0] HS_EXP = 8'd25;
`else
  localparam logic [7:0] HS_EXP = 8'd0;
`endif

  snake_game_ctrl dut (
    .clk(clk), .reset(reset),
    .up(up), .down(down), .left(left), .right(right),
    .frame_tick(frame_tick), .collision_state(collision_state),
    .state(state), .apple_trigger(apple_trigger), .move_tick(move_tick),
    .score(score), .lives(lives), .level(level), .high_score(high_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame(output logic m);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m = move_tick;
    @(negedge clk);
  endtask

  task automatic frames(input int k);
    logic m;
    for (int i = 0; i < k; i++) frame(m);
  endtask

  task automatic measure(input int lim, output int cnt);
    logic m;
    cnt = 0;
    m = 1'b0;
    while (!m && cnt < lim) begin
      frame(m);
      cnt++;
    end
  endtask

  task automatic hold(input logic [1:0] cs, input int cyc);
    collision_state = cs;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (apple_trigger) pulses++;
    end
    collision_state = 2'b00;
  endtask

  task automatic press_right();
    right = 1'b1;
    @(negedge clk);
    right = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_level", level, 0);
    chk("rst_hs", high_score, 0);
    chk("rst_move", move_tick, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold", state, 0);

    press_right();
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);

    measure(30, n);
    chk("move_first_l0", n, 12);
    measure(30, n);
    chk("move_period_l0", n, 12);

    hold(2'b10, 500);
    chk("apple_one_pulse", pulses, 1);
    chk("apple_score1", score, 1);
    frames(1);
    for (int i = 1; i < 8; i++) begin
      hold(2'b10, 3);
      frames(1);
    end
    chk("apple_pulses8", pulses, 8);
    chk("score8", score, 8);
    chk("level1", level, 1);
    for (int i = 8; i < 24; i++) begin
      hold(2'b10, 3);
      frames(1);
    end
    chk("score24", score, 24);
    chk("level3", level, 3);
    measure(30, n);
    measure(30, n);
    chk("move_period_l3", n, 9);

    hold(2'b01, 3);
    chk("hit1_state", state, 2);
    chk("hit1_lives", lives, 2);
    up = 1'b1;
    hold(2'b01, 5);
    up = 1'b0;
    chk("respawn_hit_ign", lives, 2);
    frames(59);
    chk("respawn_59", state, 2);
    frames(1);
    chk("respawn_60", state, 1);

    pulses = 0;
    hold(2'b11, 4);
    chk("cs11_pulses", pulses, 0);
    chk("cs11_score", score, 24);
    chk("cs11_lives", lives, 2);

    hold(2'b10, 3);
    hold(2'b01, 3);
    chk("frame_apple_hit_pulses", pulses, 1);
    chk("frame_apple_hit_score", score, 25);
    chk("hit2_lives", lives, 1);
    chk("hit2_state", state, 2);
    frames(60);
    chk("respawn2_done", state, 1);

    hold(2'b01, 3);
    chk("over_state", state, 3);
    chk("over_lives", lives, 0);
    chk("over_hs", high_score, HS_EXP);
    right = 1'b1;
    up = 1'b1;
    frames(119);
    chk("over_btn_ign", state, 3);
    chk("over_score_hold", score, 25);
    chk("over_level_hold", level, 3);
    right = 1'b0;
    up = 1'b0;
    frames(1);
    chk("over_to_idle", state, 0);
    chk("idle_score_hold", score, 25);

    press_right();
    chk("new_state", state, 1);
    chk("new_score", score, 0);
    chk("new_lives", lives, 3);
    chk("new_level", level, 0);
    chk("new_hs", high_score, HS_EXP);

    hold(2'b01, 2);
    chk("hit3_state", state, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_lives", lives, 3);
    chk("async_rst_hs", high_score, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_move", move_tick, 0);
    chk("post_rst_apple", apple_trigger, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
